// File: rtl/mem_pkg.sv
// Shared memory-interface types and helpers for the multicycle CPU.
// Used by the memory responder, the control unit and the datapath.
package mem_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int DEPTH_LOG2_DEF = 8;
    localparam int LATENCY_DEF    = 2;
    localparam int CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic err_misalign(logic [1:0] lo);
        return lo != 2'b00;
    endfunction

    // Any address bit above the RAM word range flags an error.
    function automatic logic err_range(logic [63:0] a, int depth_log2);
        return (a >> (depth_log2 + 2)) != 64'd0;
    endfunction

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous word RAM, write-first on read-during-write.
// No reset: contents survive a responder reset.
module sp_ram #(
    parameter int DATA_W = 32,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     a,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= din;
            dout   <= din;
        end else begin
            dout <= mem[a];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: one request at a time, a one-cycle
// ready pulse after LATENCY wait cycles, with read data and error flag.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be 0..15");
    end

    localparam logic [CNT_W-1:0] LAT = CNT_W'(LATENCY);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              go_resp;
    logic              accept;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_err;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic [DATA_W-1:0] resp_data;

    assign accept = (state_q == IDLE) && req;

    // With zero latency the RAM access happens on the accept edge itself,
    // so the live request must reach the RAM while idle.
    assign cur_we    = (state_q == IDLE) ? we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? wdata : wdata_q;
    assign cur_err   = err_misalign(cur_addr[1:0])
                     | err_range(64'(cur_addr), DEPTH_LOG2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ram_we = go_resp && cur_we && !cur_err && reset;

    sp_ram #(
        .DATA_W (DATA_W),
        .AW     (DEPTH_LOG2)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .a    (cur_addr[DEPTH_LOG2+1:2]),
        .din  (cur_wdata),
        .dout (ram_dout)
    );

    assign ready     = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign err       = ready && cur_err;
    assign resp_data = cur_err ? '0 : ram_dout;
    assign rdata     = ready ? resp_data : rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == RESP) begin
                rdata_q <= resp_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: five instances at latencies 2,0,1,5,15,
// directed and random transactions against a word-array model.
module tb_mem_responder;

    localparam int NL = 5;

    function automatic int lat_of(int i);
        case (i)
            0: return 2;
            1: return 0;
            2: return 1;
            3: return 5;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [NL];
    logic        we [NL];
    logic [31:0] addr [NL];
    logic [31:0] wdata [NL];
    logic [31:0] rdata [NL];
    logic        ready [NL];
    logic        err [NL];
    logic        busy [NL];

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [NL][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        mem_responder #(.LATENCY(lat_of(g))) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .req   (req[g]),
            .we    (we[g]),
            .addr  (addr[g]),
            .wdata (wdata[g]),
            .rdata (rdata[g]),
            .ready (ready[g]),
            .err   (err[g]),
            .busy  (busy[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd1024);
    endfunction

    // One transaction; ready must appear exactly LATENCY+1 negedges
    // after the accept edge. noise drives junk on req/we/addr while busy.
    task automatic txn(int i, bit w, logic [31:0] a, logic [31:0] d,
                       bit noise);
        int lat = lat_of(i);
        bit e = bad_addr(a);
        logic [31:0] exp;
        if (e) exp = 32'd0;
        else if (w) exp = d;
        else exp = mdl[i][a/4];
        if (!e && w) mdl[i][a/4] = d;
        @(negedge clk);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        #1 req[i] = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k <= lat) begin
                chk($sformatf("L%0d wait-ready k%0d", lat, k), 32'(ready[i]), 0);
                chk($sformatf("L%0d wait-busy k%0d", lat, k), 32'(busy[i]), 1);
            end else begin
                chk($sformatf("L%0d ready a=%h", lat, a), 32'(ready[i]), 1);
                chk($sformatf("L%0d resp-busy a=%h", lat, a), 32'(busy[i]), 1);
                chk($sformatf("L%0d err a=%h", lat, a), 32'(err[i]), 32'(e));
                chk($sformatf("L%0d rdata a=%h", lat, a), rdata[i], exp);
            end
            req[i]   = noise && k <= lat && $urandom_range(1) == 1;
            we[i]    = 1'($urandom);
            addr[i]  = $urandom;
            wdata[i] = $urandom;
        end
        req[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("L%0d idle-ready", lat), 32'(ready[i]), 0);
        chk($sformatf("L%0d idle-busy", lat), 32'(busy[i]), 0);
        chk($sformatf("L%0d rdata-hold", lat), rdata[i], exp);
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a = 32'($urandom_range(31)) * 4;
        int sel = $urandom_range(7);
        if (sel == 0) a = a + 32'($urandom_range(3, 1));
        if (sel == 1) a = a | (32'd1 << $urandom_range(31, 10));
        return a;
    endfunction

    initial begin
        logic [31:0] cur;
        for (int i = 0; i < NL; i++) begin
            req[i] = 0; we[i] = 0; addr[i] = 0; wdata[i] = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NL; i++) begin
            chk($sformatf("rst ready %0d", i), 32'(ready[i]), 0);
            chk($sformatf("rst busy %0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst err %0d", i), 32'(err[i]), 0);
            chk($sformatf("rst rdata %0d", i), rdata[i], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < NL; i++)
            for (int w = 0; w < 32; w++)
                txn(i, 1, 32'(w * 4), (w == 0) ? 32'd0 : $urandom, 0);

        txn(0, 1, 32'h10, 32'hDEADBEEF, 0);
        txn(0, 0, 32'h10, 0, 0);
        txn(0, 0, 32'h13, 0, 0);
        txn(0, 0, 32'h10, 0, 0);
        txn(0, 1, 32'h400, 32'h1, 0);
        txn(0, 0, 32'h0, 0, 0);
        txn(0, 1, 32'h3FC, 32'hA5A5F00D, 0);
        txn(0, 0, 32'h3FC, 0, 0);
        txn(0, 0, 32'h8000_0000, 0, 0);

        // Continuous req at latency 0: accept, respond, accept, ...
        cur = 32'h10;
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = cur;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            chk($sformatf("hold ready n%0d", n), 32'(ready[1]), 32'(n % 2));
            if (n % 2 == 1) begin
                chk($sformatf("hold rdata n%0d", n), rdata[1], mdl[1][cur/4]);
            end else begin
                cur = 32'($urandom_range(31)) * 4;
                addr[1] = cur;
            end
        end
        req[1] = 1'b0;
        @(negedge clk);
        chk("hold stop", 32'(ready[1]), 0);

        // Reset one cycle into WAIT aborts the write.
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h55;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort ready", 32'(ready[0]), 0);
        chk("abort busy", 32'(busy[0]), 0);
        chk("abort err", 32'(err[0]), 0);
        chk("abort rdata", rdata[0], 0);
        @(negedge clk);
        chk("abort still idle", 32'(ready[0]), 0);
        rst_n = 1'b1;
        txn(0, 0, 32'h20, 0, 0);

        for (int i = 0; i < NL; i++)
            for (int t = 0; t < 30; t++)
                txn(i, 1'($urandom), rnd_addr(), $urandom, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's word memory interface. Accepts one read or write request at a time from the control-unit/datapath initiator.
- Inserts a configurable number of wait states, performs the access on an internal word-addressed RAM, and returns a one-cycle ready pulse with read data and an error flag.
- Sits between the CPU datapath (address mux driven by IorD, MemWrite) and on-chip RAM. It replaces the ideal zero-latency memory so that the control FSM must handshake.

Parameters:
- ADDR_W, 32, byte address width from the datapath.
- DATA_W, 32, data word width.
- DEPTH_LOG2, 8, log2 of RAM depth in words (256 words).
- LATENCY, 2, wait cycles between acceptance and response (0..15).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- req  input  1  request strobe from initiator, sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr  input  ADDR_W  byte address; sampled with req.
- wdata  input  DATA_W  write data; sampled with req.
- rdata  output  DATA_W  read data; valid while ready=1; held until next response.
- ready  output  1  one-cycle response pulse.
- err  output  1  valid with ready. Set on misaligned (addr[1:0]!=0) or out-of-range (addr[ADDR_W-1:DEPTH_LOG2+2]!=0) access.
- busy  output  1  high from acceptance until the response cycle inclusive.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=0, err=0, busy=0, rdata=0, wait counter=0, latched request regs=0. RAM contents are not cleared.
- Reset asserted mid-operation aborts the transaction. A pending write is not performed; no ready is issued.
- States: IDLE, WAIT, RESP.
- IDLE: on an edge with req=1, latch we/addr/wdata, set busy=1, and compute the error condition.
  - LATENCY=0: go to RESP.
  - LATENCY>0: go to WAIT with counter=LATENCY.
- WAIT: counter decrements each edge. At the edge where counter==1, go to RESP.
- Latency: request accepted at edge t; ready=1 during the cycle following edge t+LATENCY (LATENCY=2 -> ready in the 3rd cycle after the accept edge).
- Entering RESP (same edge):
  - err=0 and we=1: RAM[addr[DEPTH_LOG2+1:2]] <= wdata; rdata <= wdata.
  - err=0 and we=0: rdata <= RAM word (synchronous read).
  - err=1: no RAM write; rdata <= 0.
- RESP: ready=1, busy=1 for exactly one cycle, then IDLE at the next edge. err is meaningful only while ready=1 and returns to 0 when leaving RESP.
- req is ignored in WAIT and RESP. It is not queued.
- A req still high in the first IDLE cycle after RESP is a new request. Initiators drop req on seeing ready.
- Back-to-back: a read of the address just written returns the new data. Minimum spacing between accepts is LATENCY+2 cycles.
- Address wrap: none; high address bits outside the RAM flag err rather than aliasing.
- Counter width: 4 bits. LATENCY >15 is a parameter error (elaboration assertion).

Decomposition:
- Shared package mem_pkg:
  - state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - ERR_MISALIGN / ERR_RANGE condition helpers;
  - default widths, shared with the control unit and datapath.
- One sub-module: sp_ram.
  - Single-port synchronous RAM: clk, we, word address, din, dout.
  - No reset; write-first read-during-write.

Test Plan:
- Write then read (LATENCY=2): write addr=0x10, wdata=0xDEADBEEF; after ready, read addr=0x10 -> ready exactly 3 cycles after each accept edge, rdata=0xDEADBEEF, err=0, busy high 3 cycles.
- Misaligned: read addr=0x13 -> ready after LATENCY, err=1, rdata=0; subsequent read of 0x10 still returns 0xDEADBEEF.
- Out of range (DEPTH_LOG2=8): write addr=0x400, wdata=0x1 -> err=1; read addr=0x0 unchanged (prior value 0x0 preserved, no aliasing).
- req held high continuously with LATENCY=0: accepts occur every 2 cycles, ready alternates 1/0, each read returns correct word; req pulses during WAIT/RESP are ignored (no extra ready).
- Reset mid-WAIT: write addr=0x20, wdata=0x55 accepted, reset=0 one cycle later -> outputs 0 immediately (async), no ready; after release, read 0x20 returns the pre-reset contents, not 0x55.
- Sweep LATENCY in {0,1,5,15}: ready cycle = accept edge + LATENCY + 1 for each.
